// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO between bus-side producers and datapath
//   consumers. Offers a registered-output or first-word-fall-through read port,
//   a fill count, programmable almost-full/almost-empty levels, a synchronous
//   flush and sticky overflow/underflow flags.
//
// Parameters
//   DATA_W    data word width in bits
//   ADDR_W    address width, DEPTH = 2**ADDR_W words (ADDR_W >= 1)
//   FWFT      0 = registered output, 1 = first-word-fall-through
//   AF_LEVEL  o_almost_full  when count >= AF_LEVEL
//   AE_LEVEL  o_almost_empty when count <= AE_LEVEL
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous, active-high reset
//   i_flush          synchronous clear of pointers, count and data_out
//   i_err_clr        synchronous clear of the sticky error flags
//   i_wr / i_data_in write request and write data
//   i_rd             read (pop) request
//   o_data_out       read data
//   o_full/o_empty   count == DEPTH / count == 0
//   o_almost_full    count >= AF_LEVEL
//   o_almost_empty   count <= AE_LEVEL
//   o_count          words stored, 0..DEPTH
//   o_overflow       sticky: write attempted while full and not popping
//   o_underflow      sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 3,
   parameter bit FWFT     = 1'b0,
   parameter int AF_LEVEL = 2**ADDR_W - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_flush,
   input  logic              i_err_clr,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_data_in,
   input  logic              i_rd,
   output logic [DATA_W-1:0] o_data_out,
   output logic              o_full,
   output logic              o_empty,
   output logic              o_almost_full,
   output logic              o_almost_empty,
   output logic [ADDR_W:0]   o_count,
   output logic              o_overflow,
   output logic              o_underflow
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] C_AF    = AF_LEVEL[ADDR_W:0];
   localparam logic [ADDR_W:0] C_AE    = AE_LEVEL[ADDR_W:0];

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W:0]   r_wr_ptr;
   logic [ADDR_W:0]   r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_overflow;
   logic              r_underflow;

   logic              w_empty;
   logic              w_full;
   logic              w_rd_en;
   logic              w_wr_en;
   logic              w_rd_commit;
   logic              w_wr_commit;
   logic [DATA_W-1:0] w_head;

   // Status is decoded from the registered count, so every flag is glitch-free
   // across pointer wrap.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == C_DEPTH);

   // A write into a full FIFO is accepted when the same cycle pops a word.
   assign w_rd_en = i_rd && !w_empty;
   assign w_wr_en = i_wr && (!w_full || w_rd_en);

   // Flush wins over both ports: accepted requests are simply dropped.
   assign w_rd_commit = w_rd_en && !i_flush;
   assign w_wr_commit = w_wr_en && !i_flush;

   assign w_head = r_mem[r_rd_ptr[ADDR_W-1:0]];

   // NOTE: state registers use non-blocking assignments and an asynchronous
   // reset branch first, so every register sees the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_commit) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_commit) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_commit, w_rd_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; pointers and count define which
   // entries are meaningful, so clearing the array would only cost logic.
   always_ff @(posedge clk) begin
      if (w_wr_commit) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data_in;
   end

   // Sticky error flags: a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= (i_wr && !w_wr_en) || (r_overflow  && !i_err_clr);
         r_underflow <= (i_rd &&  w_empty) || (r_underflow && !i_err_clr);
      end
   end

   generate
      if (FWFT) begin : g_fwft
         // Head word is presented directly; zero while nothing is stored.
         assign o_data_out = w_empty ? '0 : w_head;
      end else begin : g_reg
         logic [DATA_W-1:0] r_data_out;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_data_out <= '0;
            end else if (i_flush) begin
               r_data_out <= '0;
            end else if (w_rd_commit) begin
               r_data_out <= w_head;
            end
         end

         assign o_data_out = r_data_out;
      end
   endgenerate

   assign o_full         = w_full;
   assign o_empty        = w_empty;
   assign o_almost_full  = (r_count >= C_AF);
   assign o_almost_empty = (r_count <= C_AE);
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule
